// File: rtl/matrix_input_parser.sv
// matrix_input_parser: parses whitespace-separated ASCII decimal tokens
// (rows, cols, then row-major elements) from the UART receive stream and
// writes each element to matrix storage. A blank line after at least one
// element zero-fills the remainder of the matrix.
module matrix_input_parser #(
  parameter int unsigned MAX_DIM = 5,
  parameter int unsigned VAL_MAX = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en_input,
  input  logic [7:0]  i_base_addr,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_wr_en,
  output logic [7:0]  o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic [31:0] o_m,
  output logic [31:0] o_n,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  localparam int unsigned CW      = $clog2(MAX_DIM * MAX_DIM + 1);
  localparam logic [15:0] DIM_LIM = 16'(MAX_DIM);
  localparam logic [15:0] VAL_LIM = 16'(VAL_MAX);

  typedef enum logic [2:0] {
    IDLE, GET_M, GET_N, GET_ELEM, PAD, DONE, ERR
  } state_t;

  state_t        state, state_nx;
  logic [15:0]   acc, acc_nx;
  logic          ovf, ovf_nx;
  logic          digit, digit_nx;
  logic          line, line_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic          wr_en_nx;
  logic [7:0]    wr_addr_nx;
  logic [31:0]   wr_data_nx, m_nx, n_nx;
  logic [1:0]    code_nx;
  logic [19:0]   dsum;
  logic [31:0]   total;
  logic          is_digit, is_delim, is_lf, dim_ok, val_ok;

  // Byte classification, accumulator arithmetic and status decode
  always_comb begin
    is_digit = (i_rx_data >= 8'd48) && (i_rx_data <= 8'd57);
    is_lf    = (i_rx_data == 8'd10);
    is_delim = is_lf || (i_rx_data == 8'd13) || (i_rx_data == 8'd32);
    dsum     = {4'd0, acc} * 20'd10 + {16'd0, i_rx_data[3:0]};
    cnt_inc  = cnt + CW'(1);
    total    = o_m * o_n;
    dim_ok   = !ovf && (acc != 16'd0) && (acc <= DIM_LIM);
    val_ok   = !ovf && (acc <= VAL_LIM);
    o_done   = (state == DONE);
    o_err    = (state == ERR);
  end

  // Next-state and datapath update
  always_comb begin
    state_nx   = state;
    acc_nx     = acc;
    ovf_nx     = ovf;
    digit_nx   = digit;
    line_nx    = line;
    cnt_nx     = cnt;
    wr_en_nx   = 1'b0;
    wr_addr_nx = o_wr_addr;
    wr_data_nx = o_wr_data;
    m_nx       = o_m;
    n_nx       = o_n;
    code_nx    = o_err_code;

    unique case (state)
      IDLE: begin
        acc_nx   = '0;
        ovf_nx   = 1'b0;
        digit_nx = 1'b0;
        line_nx  = 1'b0;
        cnt_nx   = '0;
        code_nx  = '0;
        if (i_en_input) state_nx = GET_M;
      end

      GET_M, GET_N, GET_ELEM: begin
        if (!i_en_input) begin
          state_nx = IDLE;
        end else if (i_rx_valid) begin
          if (is_digit) begin
            acc_nx   = dsum[15:0];
            ovf_nx   = ovf | (dsum[19:16] != 4'd0);
            digit_nx = 1'b1;
            line_nx  = 1'b1;
          end else if (is_delim) begin
            if (digit) begin
              acc_nx   = '0;
              ovf_nx   = 1'b0;
              digit_nx = 1'b0;
              if (state == GET_M) begin
                if (dim_ok) begin
                  m_nx     = 32'(acc);
                  state_nx = GET_N;
                end else begin
                  code_nx  = 2'd1;
                  state_nx = ERR;
                end
              end else if (state == GET_N) begin
                if (dim_ok) begin
                  n_nx     = 32'(acc);
                  state_nx = GET_ELEM;
                end else begin
                  code_nx  = 2'd1;
                  state_nx = ERR;
                end
              end else begin
                if (val_ok) begin
                  wr_en_nx   = 1'b1;
                  wr_addr_nx = i_base_addr + 8'(cnt);
                  wr_data_nx = 32'(acc);
                  cnt_nx     = cnt_inc;
                  // Last element: PAD sees nothing left and moves to DONE,
                  // which delays o_done one cycle behind the final write.
                  if (32'(cnt_inc) == total) state_nx = PAD;
                end else begin
                  code_nx  = 2'd2;
                  state_nx = ERR;
                end
              end
            end else if (is_lf && (state == GET_ELEM) && !line && (cnt != '0)) begin
              // Empty line: issue the first pad write right away
              wr_en_nx   = 1'b1;
              wr_addr_nx = i_base_addr + 8'(cnt);
              wr_data_nx = '0;
              cnt_nx     = cnt_inc;
              state_nx   = PAD;
            end
            if (is_lf) line_nx = 1'b0;
          end else begin
            code_nx  = 2'd3;
            state_nx = ERR;
          end
        end
      end

      PAD: begin
        if (!i_en_input) begin
          state_nx = IDLE;
        end else if (32'(cnt) < total) begin
          wr_en_nx   = 1'b1;
          wr_addr_nx = i_base_addr + 8'(cnt);
          wr_data_nx = '0;
          cnt_nx     = cnt_inc;
        end else begin
          state_nx = DONE;
        end
      end

      DONE, ERR: begin
        if (!i_en_input) begin
          code_nx  = '0;
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      ovf        <= 1'b0;
      digit      <= 1'b0;
      line       <= 1'b0;
      cnt        <= '0;
      o_wr_en    <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_m        <= '0;
      o_n        <= '0;
      o_err_code <= '0;
    end else begin
      state      <= state_nx;
      acc        <= acc_nx;
      ovf        <= ovf_nx;
      digit      <= digit_nx;
      line       <= line_nx;
      cnt        <= cnt_nx;
      o_wr_en    <= wr_en_nx;
      o_wr_addr  <= wr_addr_nx;
      o_wr_data  <= wr_data_nx;
      o_m        <= m_nx;
      o_n        <= n_nx;
      o_err_code <= code_nx;
    end
  end

endmodule

// File: tb/tb_matrix_input_parser.sv
// Self-checking bench for matrix_input_parser: expected storage writes are
// queued when a stream is driven and popped as the parser emits them.
module tb_matrix_input_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_en_input = 1'b0;
  logic [7:0]  i_base_addr = 8'd0;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  i_rx_data = 8'd0;
  logic        o_wr_en;
  logic [7:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic [31:0] o_m;
  logic [31:0] o_n;
  logic        o_done;
  logic        o_err;
  logic [1:0]  o_err_code;

  int vectors = 0;
  int miscompares = 0;
  logic [39:0] sb[$];
  int wr_cycs[$];

  matrix_input_parser #(.MAX_DIM(5), .VAL_MAX(9)) dut (
    .clk(clk), .rst_n(rst_n), .i_en_input(i_en_input), .i_base_addr(i_base_addr),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_m(o_m), .o_n(o_n),
    .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  // Raises enable, streams s back-to-back (byte k driven in iteration k),
  // checks every write against the scoreboard and notes done/err iterations.
  task automatic run_stream(input string s, input int tail,
                            output int done_cyc, output int err_cyc);
    int k = 0;
    int idle = 0;
    int n = s.len();
    bit fin = 0;
    logic [39:0] exp;
    done_cyc = -1;
    err_cyc  = -1;
    wr_cycs.delete();
    @(posedge clk); #1;
    i_en_input = 1'b1;
    i_rx_valid = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      if (k < n) begin
        i_rx_valid = 1'b1;
        i_rx_data  = s[k];
      end else begin
        i_rx_valid = 1'b0;
        idle++;
      end
      @(negedge clk);
      if (o_wr_en) begin
        vectors++;
        wr_cycs.push_back(k);
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL wr_unexpected: got addr=%02h data=%0d, required no write", o_wr_addr, o_wr_data);
        end else begin
          exp = sb.pop_front();
          if ({o_wr_addr, o_wr_data} !== exp) begin
            miscompares++;
            $display("FAIL wr_data: got addr=%02h data=%0d, required addr=%02h data=%0d",
                     o_wr_addr, o_wr_data, exp[39:32], exp[31:0]);
          end
        end
      end
      if (o_done && done_cyc < 0) done_cyc = k;
      if (o_err && err_cyc < 0) err_cyc = k;
      k++;
      if (k >= n && (done_cyc >= 0 || err_cyc >= 0 || idle >= tail)) fin = 1;
    end
    i_rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_m, o_n, o_done, o_err, o_err_code} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got wr_en=%b addr=%h data=%h m=%0d n=%0d done=%b err=%b code=%0d, required all 0",
               o_wr_en, o_wr_addr, o_wr_data, o_m, o_n, o_done, o_err, o_err_code);
    end
  endtask

  task automatic test_full_matrix();
    int dc, ec;
    i_base_addr = 8'h10;
    for (int i = 0; i < 6; i++) sb.push_back({8'(8'h10 + i), 32'(i + 1)});
    run_stream("2 3\r\n1 2 3\r\n4 5 6\r\n", 20, dc, ec);
    vectors++;
    if (sb.size() != 0 || wr_cycs.size() != 6) begin
      miscompares++;
      $display("FAIL full_writes: got %0d writes, %0d left in queue, required 6 and 0", wr_cycs.size(), sb.size());
      sb.delete();
    end
    vectors++;
    if (wr_cycs.size() == 0 || dc != wr_cycs[$] + 1) begin
      miscompares++;
      $display("FAIL full_done_timing: got done iter %0d, required one after last write", dc);
    end
    vectors++;
    if (o_m !== 32'd2 || o_n !== 32'd3) begin
      miscompares++;
      $display("FAIL full_dims: got m=%0d n=%0d, required m=2 n=3", o_m, o_n);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (o_done !== 1'b1 || o_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL full_done_hold: got done=%b wr_en=%b, required done=1 wr_en=0", o_done, o_wr_en);
    end
    i_en_input = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_done !== 1'b0) begin
      miscompares++;
      $display("FAIL full_done_clear: got done=%b, required 0", o_done);
    end
  endtask

  task automatic test_pad();
    int dc, ec;
    string s = "2 2\r\n7\r\n\r\n";
    int lf = s.len() - 1;
    i_base_addr = 8'h00;
    sb.push_back({8'h00, 32'd7});
    for (int i = 1; i < 4; i++) sb.push_back({8'(i), 32'd0});
    run_stream(s, 20, dc, ec);
    vectors++;
    if (sb.size() != 0 || wr_cycs.size() != 4) begin
      miscompares++;
      $display("FAIL pad_writes: got %0d writes, %0d left in queue, required 4 and 0", wr_cycs.size(), sb.size());
      sb.delete();
    end else begin
      vectors++;
      if (wr_cycs[1] != lf + 1 || wr_cycs[3] != lf + 3) begin
        miscompares++;
        $display("FAIL pad_timing: got pad iters %0d..%0d, required %0d..%0d", wr_cycs[1], wr_cycs[3], lf + 1, lf + 3);
      end
    end
    vectors++;
    if (dc != lf + 4) begin
      miscompares++;
      $display("FAIL pad_done: got done iter %0d, required %0d", dc, lf + 4);
    end
    i_en_input = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_errors();
    string strs[5]  = '{"6 2 ", "0 ", "1 2 3 12 ", "1 1 70000 ", "1 2 4,5"};
    int    codes[5] = '{1, 1, 2, 2, 3};
    int    bad[5]   = '{1, 1, 8, 9, 5};
    int dc, ec;
    i_base_addr = 8'h20;
    for (int t = 0; t < 5; t++) begin
      if (t == 2) sb.push_back({8'h20, 32'd3});
      run_stream(strs[t], 20, dc, ec);
      vectors++;
      if (o_err !== 1'b1 || o_err_code !== 2'(codes[t]) || ec != bad[t] + 1 || dc >= 0) begin
        miscompares++;
        $display("FAIL err_%0d: got err=%b code=%0d iter=%0d done_iter=%0d, required err=1 code=%0d iter=%0d no done",
                 t, o_err, o_err_code, ec, dc, codes[t], bad[t] + 1);
      end
      vectors++;
      if (sb.size() != 0) begin
        miscompares++;
        $display("FAIL err_%0d_writes: got %0d expected writes missing, required 0", t, sb.size());
        sb.delete();
      end
      i_en_input = 1'b0;
      @(negedge clk);
      vectors++;
      if (o_err !== 1'b0 || o_err_code !== 2'd0) begin
        miscompares++;
        $display("FAIL err_%0d_clear: got err=%b code=%0d, required 0 0", t, o_err, o_err_code);
      end
    end
  endtask

  task automatic test_abort();
    int dc, ec;
    int stray = 0;
    i_base_addr = 8'h40;
    sb.push_back({8'h40, 32'd1});
    sb.push_back({8'h41, 32'd2});
    run_stream("3 3 1 2 ", 3, dc, ec);
    i_en_input = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (o_wr_en || o_done) stray++;
    end
    vectors++;
    if (sb.size() != 0 || stray != 0 || dc >= 0 || o_m !== 32'd3) begin
      miscompares++;
      $display("FAIL abort: got missing=%0d stray=%0d done_iter=%0d m=%0d, required 0 0 -1 3", sb.size(), stray, dc, o_m);
      sb.delete();
    end
    sb.push_back({8'h40, 32'd9});
    run_stream("1 1 9 ", 20, dc, ec);
    vectors++;
    if (sb.size() != 0 || dc < 0 || o_m !== 32'd1 || o_n !== 32'd1) begin
      miscompares++;
      $display("FAIL abort_rerun: got missing=%0d done_iter=%0d m=%0d n=%0d, required 0 >=0 1 1", sb.size(), dc, o_m, o_n);
      sb.delete();
    end
    i_en_input = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int dc, ec;
    i_base_addr = 8'hFE;
    sb.push_back({8'hFE, 32'd1});
    sb.push_back({8'hFF, 32'd2});
    sb.push_back({8'h00, 32'd3});
    sb.push_back({8'h01, 32'd4});
    run_stream("2 2 1 2 3 4 ", 20, dc, ec);
    vectors++;
    if (sb.size() != 0 || dc < 0 || ec >= 0) begin
      miscompares++;
      $display("FAIL wrap: got missing=%0d done_iter=%0d err_iter=%0d, required 0 >=0 -1", sb.size(), dc, ec);
      sb.delete();
    end
    i_en_input = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dc, ec;
    i_base_addr = 8'h00;
    sb.push_back({8'h00, 32'd5});
    run_stream("2 2 5 6", 0, dc, ec);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_m, o_n, o_done, o_err, o_err_code} !== '0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid: got m=%0d n=%0d addr=%h data=%0d missing=%0d, required all 0",
               o_m, o_n, o_wr_addr, o_wr_data, sb.size());
      sb.delete();
    end
    i_en_input = 1'b0;
    #7;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_blank_line();
    int dc, ec;
    i_base_addr = 8'h00;
    sb.push_back({8'h00, 32'd4});
    run_stream("\r\n1 1 4\n", 20, dc, ec);
    vectors++;
    if (sb.size() != 0 || dc < 0 || wr_cycs.size() != 1) begin
      miscompares++;
      $display("FAIL blank_line: got %0d writes missing=%0d done_iter=%0d, required 1 0 >=0", wr_cycs.size(), sb.size(), dc);
      sb.delete();
    end
    i_en_input = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #23 rst_n = 1'b1;
    test_reset();
    test_full_matrix();
    test_pad();
    test_errors();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_blank_line();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
